frv_masked_arith_seq: RTL and testbench

Multi-cycle sequencer for the arithmetic-masking ISE datapath. It accepts one masked-arithmetic request at a time from the execute stage and fetches fresh randomness from the core PRNG when the op needs it. It runs the op as a fixed sequence of single-cycle add/sub steps on one shared 32-bit adder, then returns the two-share result for writeback. Share convention: a value v is held as a pair (s1, s0) with v = s1 - s0 mod 2^32. `*_hi` carries s0; `*_lo` carries s1.

---
 rtl/frv_masked_arith_seq_if.sv | 27 ++
 rtl/frv_masked_arith_seq.sv | 76 +++++++
 tb/tb_frv_masked_arith_seq.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/frv_masked_arith_seq_if.sv
// frv_masked_arith_seq_if: request, PRNG and response channels of the masked-arithmetic sequencer.
interface frv_masked_arith_seq_if #(parameter int XLEN = 32);
   logic            req_valid;
   logic            req_ready;
   logic [1:0]      req_op;
   logic [XLEN-1:0] req_rs1_lo;
   logic [XLEN-1:0] req_rs1_hi;
   logic [XLEN-1:0] req_rs2_lo;
   logic [XLEN-1:0] req_rs2_hi;
   logic            prng_req;
   logic            prng_valid;
   logic [XLEN-1:0] prng_data;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [XLEN-1:0] rsp_lo;
   logic [XLEN-1:0] rsp_hi;
   modport master (
      output req_valid, req_op, req_rs1_lo, req_rs1_hi, req_rs2_lo, req_rs2_hi,
      output prng_valid, prng_data, rsp_ready,
      input  req_ready, prng_req, rsp_valid, rsp_lo, rsp_hi
   );
   modport slave (
      input  req_valid, req_op, req_rs1_lo, req_rs1_hi, req_rs2_lo, req_rs2_hi,
      input  prng_valid, prng_data, rsp_ready,
      output req_ready, prng_req, rsp_valid, rsp_lo, rsp_hi
   );
endinterface

// File: rtl/frv_masked_arith_seq.sv
// frv_masked_arith_seq: multi-cycle masked add/sub sequencer sharing one 32-bit adder.
module frv_masked_arith_seq #(
   parameter int XLEN = 32
) (
   input  logic                  g_clk,
   input  logic                  g_reset,
   input  logic                  flush,
   frv_masked_arith_seq_if.slave bus,
   output logic                  busy
);
   typedef enum logic [2:0] {IDLE, RND, EX0, EX1, EX2, EX3, DONE} state_t;
   localparam logic [1:0] OP_UNMASK = 2'd0;
   localparam logic [1:0] OP_MASK   = 2'd1;
   localparam logic [1:0] OP_ADD    = 2'd3;
   state_t          state, nxt;
   logic [1:0]      op;
   logic [XLEN-1:0] a1, a0, b1, b0, r, s1, s0;
   logic [XLEN-1:0] add_x, add_y, sum;
   logic            sub;
   always_ff @(posedge g_clk)
      state <= g_reset ? IDLE : nxt;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = bus.req_valid ? (bus.req_op == OP_UNMASK ? EX0 : RND) : IDLE;
         RND:     nxt = bus.prng_valid ? EX0 : RND;
         EX0:     nxt = (op == OP_UNMASK || op == OP_MASK) ? DONE : EX1;
         EX1:     nxt = op == OP_ADD ? EX2 : DONE;
         EX2:     nxt = EX3;
         EX3:     nxt = DONE;
         DONE:    nxt = bus.rsp_ready ? IDLE : DONE;
         default: nxt = IDLE;
      endcase
      if (flush) nxt = IDLE;
   end
   // Subtraction is done on the same adder as x + ~y + 1.
   always_comb begin
      sub   = state == EX0 && op == OP_UNMASK;
      add_x = state == EX0 ? a1 : state == EX1 ? a0 : state == EX2 ? s1 : s0;
      add_y = state == EX0 ? (op == OP_ADD ? b1 : op == OP_UNMASK ? a0 : r) :
              state == EX1 ? (op == OP_ADD ? b0 : r) : r;
      sum   = add_x + (add_y ^ {XLEN{sub}}) + {{(XLEN-1){1'b0}}, sub};
   end
   // Every path back to IDLE wipes all share material.
   always_ff @(posedge g_clk)
      if (g_reset || nxt == IDLE) begin
         op <= '0;
         a1 <= '0;
         a0 <= '0;
         b1 <= '0;
         b0 <= '0;
         r  <= '0;
         s1 <= '0;
         s0 <= '0;
      end else begin
         if (state == IDLE) begin
            op <= bus.req_op;
            a1 <= bus.req_rs1_lo;
            a0 <= bus.req_rs1_hi;
            b1 <= bus.req_rs2_lo;
            b0 <= bus.req_rs2_hi;
         end
         if (state == RND && bus.prng_valid) r <= bus.prng_data;
         if (state == EX0 || state == EX2) s1 <= sum;
         if (state == EX1 || state == EX3) s0 <= sum;
         if (state == EX0 && op == OP_MASK) s0 <= r;
      end
   always_comb begin
      bus.req_ready = state == IDLE;
      bus.prng_req  = state == RND;
      bus.rsp_valid = state == DONE;
      bus.rsp_lo    = state == DONE ? s1 : '0;
      bus.rsp_hi    = state == DONE ? s0 : '0;
      busy          = state != IDLE;
   end
endmodule

// File: tb/tb_frv_masked_arith_seq.sv
// tb_frv_masked_arith_seq: directed vectors plus a per-cycle value/latency model of the sequencer.
module tb_frv_masked_arith_seq;
   logic g_clk = 1'b0;
   logic g_reset = 1'b1;
   logic flush = 1'b0;
   logic busy;
   int   n_tests = 0;
   int   n_fail = 0;
   frv_masked_arith_seq_if #(.XLEN(32)) bus ();
   frv_masked_arith_seq #(.XLEN(32)) dut (
      .g_clk(g_clk), .g_reset(g_reset), .flush(flush), .bus(bus.slave), .busy(busy)
   );
   always #5 g_clk = ~g_clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   // Model: an op is "busy", waits for randomness if it needs it, then takes
   // a fixed number of steps; the result is the share formula for that op.
   bit          chk_en = 0;
   bit          m_busy = 0;
   bit          m_rnd = 0;
   int          m_cnt = 0;
   logic [1:0]  m_op;
   logic [31:0] m_a1, m_a0, m_b1, m_b0, m_r;
   function automatic int steps(input logic [1:0] op);
      return op == 2'd0 ? 1 : op == 2'd1 ? 1 : op == 2'd2 ? 2 : 4;
   endfunction
   function automatic logic [63:0] m_result();
      case (m_op)
         2'd0:    return {m_a1 - m_a0, 32'h0};
         2'd1:    return {m_a1 + m_r, m_r};
         2'd2:    return {m_a1 + m_r, m_a0 + m_r};
         default: return {m_a1 + m_b1 + m_r, m_a0 + m_b0 + m_r};
      endcase
   endfunction
   always @(posedge g_clk) begin
      if (g_reset) chk_en = 1;
      if (g_reset || flush) begin
         m_busy = 0;
         m_rnd  = 0;
         m_cnt  = 0;
      end else if (!m_busy) begin
         if (bus.req_valid) begin
            m_busy = 1;
            m_op   = bus.req_op;
            m_a1   = bus.req_rs1_lo;
            m_a0   = bus.req_rs1_hi;
            m_b1   = bus.req_rs2_lo;
            m_b0   = bus.req_rs2_hi;
            m_r    = 0;
            m_rnd  = bus.req_op != 2'd0;
            m_cnt  = steps(bus.req_op);
         end
      end else if (m_rnd) begin
         if (bus.prng_valid) begin
            m_r   = bus.prng_data;
            m_rnd = 0;
         end
      end else if (m_cnt > 0) m_cnt--;
      else if (bus.rsp_ready) m_busy = 0;
   end
   always @(negedge g_clk) begin
      bit          done;
      logic [63:0] res;
      if (chk_en) begin
         done = m_busy && !m_rnd && m_cnt == 0;
         res  = done ? m_result() : 64'h0;
         chk("req_ready", 32'(bus.req_ready), 32'(!m_busy));
         chk("busy", 32'(busy), 32'(m_busy));
         chk("prng_req", 32'(bus.prng_req), 32'(m_busy && m_rnd));
         chk("rsp_valid", 32'(bus.rsp_valid), 32'(done));
         chk("rsp_lo", bus.rsp_lo, res[63:32]);
         chk("rsp_hi", bus.rsp_hi, res[31:0]);
      end
   end
   task automatic run_op(input logic [1:0] op, input logic [31:0] a1, a0, b1, b0,
                         input int stall, input logic [31:0] rnd, exp_lo, exp_hi,
                         input int exp_cyc, input logic [31:0] exp_preq,
                         input int hold, input bit do_flush);
      int          cyc = 0;
      logic [31:0] preq = 0;
      bus.req_valid  = 1;
      bus.req_op     = op;
      bus.req_rs1_lo = a1;
      bus.req_rs1_hi = a0;
      bus.req_rs2_lo = b1;
      bus.req_rs2_hi = b0;
      do begin
         @(posedge g_clk);
         #1;
         cyc++;
         bus.req_valid  = 0;
         bus.req_rs1_lo = 0;
         bus.req_rs1_hi = 0;
         bus.req_rs2_lo = 0;
         bus.req_rs2_hi = 0;
         bus.prng_valid = cyc > stall;
         bus.prng_data  = cyc > stall ? rnd : 32'hDEADBEEF;
         if (bus.prng_req && cyc < 32) preq[cyc] = 1'b1;
      end while (!bus.rsp_valid && cyc < 40);
      bus.prng_valid = 0;
      bus.prng_data  = 0;
      chk("latency", 32'(cyc), 32'(exp_cyc));
      chk("res_lo", bus.rsp_lo, exp_lo);
      chk("res_hi", bus.rsp_hi, exp_hi);
      chk("prng_req_cycles", preq, exp_preq);
      repeat (hold) begin
         @(posedge g_clk);
         #1;
         chk("hold_lo", bus.rsp_lo, exp_lo);
         chk("hold_hi", bus.rsp_hi, exp_hi);
         chk("hold_ready", 32'(bus.req_ready), 32'd0);
      end
      if (do_flush) flush = 1;
      else bus.rsp_ready = 1;
      @(posedge g_clk);
      #1;
      flush         = 0;
      bus.rsp_ready = 0;
      chk("post_valid", 32'(bus.rsp_valid), 32'd0);
      chk("post_lo", bus.rsp_lo, 32'd0);
      chk("post_hi", bus.rsp_hi, 32'd0);
      chk("post_ready", 32'(bus.req_ready), 32'd1);
   endtask
   initial begin
      bus.req_valid  = 0;
      bus.req_op     = 0;
      bus.req_rs1_lo = 0;
      bus.req_rs1_hi = 0;
      bus.req_rs2_lo = 0;
      bus.req_rs2_hi = 0;
      bus.prng_valid = 0;
      bus.prng_data  = 0;
      bus.rsp_ready  = 0;
      repeat (2) @(posedge g_clk);
      #1;
      g_reset = 0;
      chk("rst_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_prng_req", 32'(bus.prng_req), 32'd0);
      chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_lo", bus.rsp_lo, 32'd0);
      chk("rst_hi", bus.rsp_hi, 32'd0);
      run_op(2'd0, 32'h10, 32'h3, 0, 0, 0, 32'h0, 32'hD, 32'h0, 2, 32'h0, 0, 0);
      run_op(2'd1, 32'h12345678, 32'h0, 0, 0, 0, 32'h11111111, 32'h23456789, 32'h11111111, 3, 32'h2, 0, 0);
      run_op(2'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0, 0, 32'h2, 32'h1, 32'h0, 4, 32'h2, 0, 0);
      run_op(2'd3, 32'd5, 32'd2, 32'd10, 32'd4, 3, 32'h1, 32'd16, 32'd7, 9, 32'h1E, 0, 0);
      run_op(2'd3, 32'h100, 32'h40, 32'h30, 32'h10, 0, 32'hA5A5A5A5, 32'hA5A5A6D5, 32'hA5A5A5F5, 6, 32'h2, 5, 1);
      run_op(2'd0, 32'h1000, 32'h1, 0, 0, 0, 32'h0, 32'hFFF, 32'h0, 2, 32'h0, 0, 0);
      bus.req_valid = 1;
      bus.req_op    = 2'd3;
      flush         = 1;
      @(posedge g_clk);
      #1;
      bus.req_valid = 0;
      flush         = 0;
      chk("flush_req_busy", 32'(busy), 32'd0);
      chk("flush_req_ready", 32'(bus.req_ready), 32'd1);
      bus.req_valid  = 1;
      bus.req_op     = 2'd1;
      bus.req_rs1_lo = 32'h77;
      @(posedge g_clk);
      #1;
      bus.req_valid  = 0;
      chk("rnd_prng_req", 32'(bus.prng_req), 32'd1);
      flush          = 1;
      bus.prng_valid = 1;
      bus.prng_data  = 32'h99;
      @(posedge g_clk);
      #1;
      flush          = 0;
      bus.prng_valid = 0;
      chk("rnd_flush_prng_req", 32'(bus.prng_req), 32'd0);
      chk("rnd_flush_busy", 32'(busy), 32'd0);
      bus.req_valid  = 1;
      bus.req_op     = 2'd3;
      bus.req_rs1_lo = 32'd7;
      bus.req_rs1_hi = 32'd3;
      bus.req_rs2_lo = 32'd9;
      bus.req_rs2_hi = 32'd1;
      for (int c = 1; c <= 3; c++) begin
         @(posedge g_clk);
         #1;
         bus.req_valid  = 0;
         bus.prng_valid = 1;
         bus.prng_data  = 32'h55;
      end
      bus.prng_valid = 0;
      g_reset        = 1;
      @(posedge g_clk);
      #1;
      g_reset = 0;
      chk("mid_rst_ready", 32'(bus.req_ready), 32'd1);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
      chk("mid_rst_lo", bus.rsp_lo, 32'd0);
      run_op(2'd2, 32'h20, 32'h8, 0, 0, 0, 32'h3, 32'h23, 32'hB, 4, 32'h2, 0, 0);
      repeat (2) @(posedge g_clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
